// File: rtl/imem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_pkg : shared constants, response record and parity helper for the   |
// |            instruction-memory responder.                                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package imem_pkg;

    localparam int IMEM_ADDR_W = 7;
    localparam int IMEM_DATA_W = 32;

    // RV32I "addi x0,x0,0", returned for fetches outside the implemented array.
    localparam logic [IMEM_DATA_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [IMEM_DATA_W-1:0] data;
        logic [IMEM_ADDR_W-1:0] addr;
        logic                   err;
    } rsp_t;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic even_parity(input logic [IMEM_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_responder_rsp_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rsp_fifo : synchronous FIFO with occupancy count and full/empty flags.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rsp_fifo #(
    parameter  int WIDTH = 40,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = bump(wr_ptr_q);
        if (pop_i)  rd_ptr_d = bump(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) store_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = store_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_mem_responder : instruction memory serving in-order fetches over   |
// | valid/ready, with a side load port. Optional macro IMEM_PARITY_EN adds   |
// | per-word even parity and the parity_inject pin.                          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module instr_mem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 128,
    parameter int RSP_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
`ifdef IMEM_PARITY_EN
    input  logic                  parity_inject,
`endif
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int ENTRY_W  = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int CNT_W    = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int CREDIT_W = CNT_W + 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP_L   = DATA_WIDTH'(NOP_WORD);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_oor_q;
    logic                  inflight_q, inflight_d;

    logic                  fetch_in_range, load_in_range;
    logic                  accept, pop, push, stage_err;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full, fifo_empty;
    logic [CREDIT_W-1:0]   credit;
    logic [ENTRY_W-1:0]    push_entry, head_entry;

    assign fetch_in_range = ({1'b0, req_addr}  < DEPTH_L);
    assign load_in_range  = ({1'b0, load_addr} < DEPTH_L);

    // Credit counts queued plus in-flight responses, freeing the slot popped this cycle.
    assign pop       = rsp_valid & rsp_ready;
    assign credit    = CREDIT_W'(fifo_count) + CREDIT_W'(inflight_q) - CREDIT_W'(pop);
    assign req_ready = reset & (credit < CREDIT_W'(RSP_FIFO_DEPTH));
    assign accept    = req_valid & req_ready;
    assign push      = inflight_q & ~fifo_full;

    assign inflight_d = accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) inflight_q <= 1'b0;
        else        inflight_q <= inflight_d;
    end

    // Non-blocking read and write on the same edge give read-before-write.
    always_ff @(posedge clk) begin
        if (load_en && load_in_range) mem_q[load_addr] <= load_data;
        if (accept) begin
            rd_addr_q <= req_addr;
            rd_oor_q  <= ~fetch_in_range;
            if (fetch_in_range) rd_data_q <= mem_q[req_addr];
            else                rd_data_q <= NOP_L;
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_q [DEPTH];
    logic rd_par_q;

    always_ff @(posedge clk) begin
        if (load_en && load_in_range) par_q[load_addr] <= even_parity(load_data) ^ parity_inject;
        if (accept) begin
            if (fetch_in_range) rd_par_q <= par_q[req_addr];
            else                rd_par_q <= even_parity(NOP_L);
        end
    end

    assign stage_err = rd_oor_q | (even_parity(rd_data_q) != rd_par_q);
`else
    assign stage_err = rd_oor_q;
`endif

    assign push_entry = {stage_err, rd_addr_q, rd_data_q};

    rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rsp_valid = ~fifo_empty;

    always_comb begin
        rsp_data = '0;
        rsp_addr = '0;
        rsp_err  = 1'b0;
        if (rsp_valid) {rsp_err, rsp_addr, rsp_data} = head_entry;
    end

endmodule
`default_nettype wire
